// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART RX state machine.
// A write happens on each rising edge of the RX ready strobe.
// Bytes are presented first-word-fall-through over a valid/ready interface,
// with a registered count, full/empty flags and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int unsigned DATA  = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_divided_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [DATA-1:0]          i_wr_data,
  input  logic                     i_wr_stb,
  output logic [DATA-1:0]          o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  input  logic                     i_clr_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovf_q, ovf_d;
  logic            stb_q, stb_d;
  logic            push_req, pop, push;

  // Strobe edge detect plus push/pop qualification.
  always_comb begin
    push_req = i_en & i_wr_stb & ~stb_q;
    pop      = i_en & ~empty_q & i_rd_ready;
    push     = push_req & (~full_q | pop);
  end

  // Next-state for pointers, count, flags and the strobe history.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    stb_d    = stb_q;

    if (i_en) begin
      stb_d = i_wr_stb;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A set in the same cycle as a clear leaves the flag set.
    if (i_en & i_clr_overflow) begin
      ovf_d = 1'b0;
    end
    if (push_req & full_q & ~pop) begin
      ovf_d = 1'b1;
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // Control state register; strobe history resets high to ignore a strobe held through reset.
  always_ff @(posedge i_divided_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      stb_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      stb_q    <= stb_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge i_divided_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Head-of-queue read, forced to zero while empty.
  always_comb begin
    o_rd_data = '0;
    if (!empty_q) begin
      o_rd_data = mem_q[rd_ptr_q];
    end
  end

  assign o_rd_valid = ~empty_q;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes,
// a monitor compares every accepted head byte against the queue.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] wr_data;
  logic       wr_stb;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       clr_ovf;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.DATA(8), .DEPTH(16)) dut (
    .i_divided_clk  (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_wr_data      (wr_data),
    .i_wr_stb       (wr_stb),
    .o_rd_data      (rd_data),
    .o_rd_valid     (rd_valid),
    .i_rd_ready     (rd_ready),
    .o_count        (count),
    .o_full         (full),
    .o_empty        (empty),
    .o_overflow     (ovf),
    .i_clr_overflow (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobe pulse; the byte is queued as expected only if the FIFO should accept it.
  task automatic strobe(input logic [7:0] d, input bit accept);
    wr_data = d;
    wr_stb  = 1'b1;
    if (accept) exp_q.push_back(d);
    tick(1);
    wr_stb = 1'b0;
    tick(1);
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    tick(n);
    rd_ready = 1'b0;
  endtask

  // Monitor: a handshake seen here is consumed on the next rising edge.
  always @(negedge clk) begin
    if (!rst && en && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(rd_data), 32'hDEAD);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; wr_data = '0; wr_stb = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // 1: single byte, one-cycle latency
    strobe(8'hA5, 1'b1);
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_data", 32'(rd_data), 32'hA5);
    chk("t1_count", 32'(count), 1);
    drain(1);
    chk("t1_empty", 32'(empty), 1);

    // 2: strobe held high gives one write
    wr_data = 8'h3C; wr_stb = 1'b1; exp_q.push_back(8'h3C);
    tick(20);
    wr_stb = 1'b0;
    tick(1);
    chk("t2_count", 32'(count), 1);
    drain(1);
    chk("t2_count_after", 32'(count), 0);

    // 3: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) strobe(8'(i), 1'b1);
    chk("t3_full", 32'(full), 1);
    chk("t3_count", 32'(count), 16);
    chk("t3_ovf_before", 32'(ovf), 0);
    strobe(8'hFF, 1'b0);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_count_ovf", 32'(count), 16);
    chk("t3_full_ovf", 32'(full), 1);
    drain(16);
    chk("t3_empty", 32'(empty), 1);
    chk("t3_data_empty", 32'(rd_data), 0);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(ovf), 0);

    // 4: full FIFO, push concurrent with pop
    for (int i = 0; i < 16; i++) strobe(8'(8'h10 + i), 1'b1);
    wr_data = 8'h77; wr_stb = 1'b1; rd_ready = 1'b1; exp_q.push_back(8'h77);
    tick(1);
    wr_stb = 1'b0; rd_ready = 1'b0;
    tick(1);
    chk("t4_count", 32'(count), 16);
    chk("t4_ovf", 32'(ovf), 0);
    chk("t4_full", 32'(full), 1);
    chk("t4_head", 32'(rd_data), 32'h11);
    drain(16);
    chk("t4_empty", 32'(empty), 1);

    // 5a: strobe while disabled is lost
    en = 1'b0;
    wr_data = 8'h55; wr_stb = 1'b1;
    tick(1);
    wr_stb = 1'b0;
    tick(1);
    en = 1'b1;
    tick(2);
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);

    // 5b: overflow set wins over clear
    for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i), 1'b1);
    wr_data = 8'hEE; wr_stb = 1'b1; clr_ovf = 1'b1;
    tick(1);
    wr_stb = 1'b0; clr_ovf = 1'b0;
    tick(1);
    chk("t5_ovf_set_wins", 32'(ovf), 1);
    chk("t5_count", 32'(count), 16);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("t5_ovf_clr", 32'(ovf), 0);
    drain(16);
    chk("t5_empty_end", 32'(empty), 1);

    // 6: async reset mid-burst, strobe held through release
    for (int i = 0; i < 5; i++) strobe(8'(8'h40 + i), 1'b1);
    chk("t6_count5", 32'(count), 5);
    chk("t6_head", 32'(rd_data), 32'h40);
    #2;
    wr_data = 8'h99; wr_stb = 1'b1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_async_count", 32'(count), 0);
    chk("t6_async_empty", 32'(empty), 1);
    chk("t6_async_data", 32'(rd_data), 0);
    chk("t6_async_valid", 32'(rd_valid), 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("t6_held_stb", 32'(count), 0);
    wr_stb = 1'b0;
    tick(1);
    strobe(8'h5A, 1'b1);
    chk("t6_after_count", 32'(count), 1);
    chk("t6_after_data", 32'(rd_data), 32'h5A);
    drain(1);
    chk("t6_empty_end", 32'(empty), 1);

    tick(2);
    chk("scoreboard_left", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
